sd_cmd_ctrl: RTL and testbench

Command-line sequencer for the SD host controller. Accepts a command index and argument, builds the 48-bit SD command frame with a serially computed CRC7, and shifts it out MSB first on the CMD line. When a response is expected, it waits for the card's response within a bounded window, captures the 48-bit response, and checks its CRC7. It sits between the host register interface and the CMD pad; the data-line path is out of scope.

---
 rtl/sd_cmd_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sd_cmd_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_ctrl
// Brief    : SD CMD-line sequencer: serial command frame with CRC7 and 48-bit
//            response capture. Define SD_CMD_RESP_CRC_CHECK_EN to check the
//            response CRC7 and end bit.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_ctrl #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_resp_expected,
    input  logic        i_cmd_in,
    output logic        o_cmd_out,
    output logic        o_cmd_oe,
    output logic        o_busy,
    output logic        o_done,
    output logic [5:0]  o_resp_index,
    output logic [31:0] o_resp_arg,
    output logic        o_crc_err,
    output logic        o_timeout
);

    localparam int c_CNT_W = ($clog2(RESP_TIMEOUT + 1) > 6) ? $clog2(RESP_TIMEOUT + 1) : 6;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(47);
    localparam logic [c_CNT_W-1:0] c_BODY_END = c_CNT_W'(40);
    localparam logic [c_CNT_W-1:0] c_CRC_END  = c_CNT_W'(38);
    localparam logic [c_CNT_W-1:0] c_TMO      = c_CNT_W'(RESP_TIMEOUT);
`ifdef SD_CMD_RESP_CRC_CHECK_EN
    localparam int c_RX_W = 46;   // response bits 45..0
`else
    localparam int c_RX_W = 38;   // response bits 45..8
`endif
    localparam logic [c_CNT_W-1:0] c_RX_END = c_CNT_W'(c_RX_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_TURN = 3'd2,
        S_WAIT = 3'd3,
        S_RX   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [39:0]         r_sh;
    logic [6:0]          r_crc;
    logic                r_resp_exp;
    logic [c_RX_W-1:0]   r_rx;
    logic [5:0]          r_resp_index;
    logic [31:0]         r_resp_arg;
    logic                r_timeout;
    logic                w_tx_bit;

    function automatic logic [6:0] f_crc7(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_TX;
            S_TX:   if (r_cnt == c_LAST) w_next = r_resp_exp ? S_TURN : S_DONE;
            S_TURN: if (r_cnt == c_CNT_W'(1)) w_next = S_WAIT;
            S_WAIT: begin
                if (r_cnt == c_TMO)  w_next = S_DONE;
                else if (!i_cmd_in)  w_next = S_RX;
            end
            S_RX:   if (r_cnt == c_LAST) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Body bits come from the shift register, then the CRC is shifted out, then the end bit.
    always_comb begin
        w_tx_bit = 1'b1;
        if (r_cnt < c_BODY_END)   w_tx_bit = r_sh[39];
        else if (r_cnt != c_LAST) w_tx_bit = r_crc[6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_sh         <= '0;
            r_crc        <= '0;
            r_resp_exp   <= 1'b0;
            r_rx         <= '0;
            r_resp_index <= '0;
            r_resp_arg   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_TX || r_state == S_TURN || r_state == S_RX ||
                     (r_state == S_WAIT && i_cmd_in))
                r_cnt <= r_cnt + c_CNT_W'(1);

            case (r_state)
                S_IDLE: if (i_start) begin
                    r_sh         <= {2'b01, i_cmd_index, i_cmd_arg};
                    r_crc        <= '0;
                    r_resp_exp   <= i_resp_expected;
                    r_resp_index <= '0;
                    r_resp_arg   <= '0;
                    r_timeout    <= 1'b0;
                end
                S_TX: begin
                    if (r_cnt < c_BODY_END) begin
                        r_crc <= f_crc7(r_crc, r_sh[39]);
                        r_sh  <= {r_sh[38:0], 1'b0};
                    end else begin
                        r_crc <= {r_crc[5:0], 1'b0};
                    end
                end
                S_WAIT: begin
                    if (r_cnt == c_TMO) r_timeout <= 1'b1;
                    else if (!i_cmd_in) begin
                        r_crc <= '0;
                        r_rx  <= '0;
                    end
                end
                S_RX: begin
                    // cnt 0 samples the transmission bit, which is not stored.
                    if (r_cnt >= c_CNT_W'(1) && r_cnt <= c_RX_END)
                        r_rx <= {r_rx[c_RX_W-2:0], i_cmd_in};
`ifdef SD_CMD_RESP_CRC_CHECK_EN
                    if (r_cnt <= c_CRC_END)
                        r_crc <= f_crc7(r_crc, i_cmd_in);
`endif
                    if (r_cnt == c_LAST) begin
                        r_resp_index <= r_rx[c_RX_W-1 -: 6];
                        r_resp_arg   <= r_rx[c_RX_W-7 -: 32];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    logic r_crc_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_crc_err <= 1'b0;
        else if (r_state == S_IDLE && i_start)
            r_crc_err <= 1'b0;
        else if (r_state == S_RX && r_cnt == c_LAST)
            r_crc_err <= (r_rx[7:1] != r_crc) || !r_rx[0];
    end
    assign o_crc_err = r_crc_err;
`else
    logic w_unused_crc_end;
    assign w_unused_crc_end = (c_CRC_END == c_LAST);
    assign o_crc_err = 1'b0;
`endif

    assign o_cmd_oe     = (r_state == S_TX);
    assign o_cmd_out    = (r_state == S_TX) ? w_tx_bit : 1'b1;
    assign o_busy       = (r_state == S_TX) || (r_state == S_TURN) ||
                          (r_state == S_WAIT) || (r_state == S_RX);
    assign o_done       = (r_state == S_DONE);
    assign o_resp_index = r_resp_index;
    assign o_resp_arg   = r_resp_arg;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_ctrl
// Brief    : Directed scoreboard bench for sd_cmd_ctrl (frames, response, timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_ctrl;

    localparam int RESP_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [5:0]  i_cmd_index = '0;
    logic [31:0] i_cmd_arg = '0;
    logic        i_resp_expected = 1'b0;
    logic        i_cmd_in = 1'b1;
    logic        o_cmd_out, o_cmd_oe, o_busy, o_done, o_crc_err, o_timeout;
    logic [5:0]  o_resp_index;
    logic [31:0] o_resp_arg;

    always #5 clk = ~clk;

    sd_cmd_ctrl #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_cmd_index(i_cmd_index),
        .i_cmd_arg(i_cmd_arg), .i_resp_expected(i_resp_expected), .i_cmd_in(i_cmd_in),
        .o_cmd_out(o_cmd_out), .o_cmd_oe(o_cmd_oe), .o_busy(o_busy), .o_done(o_done),
        .o_resp_index(o_resp_index), .o_resp_arg(o_resp_arg),
        .o_crc_err(o_crc_err), .o_timeout(o_timeout)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
    localparam logic c_BAD_CRC_FLAG = 1'b1;
`else
    localparam logic c_BAD_CRC_FLAG = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL scoreboard_empty: observed %0h expected queued entry", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] body;
        logic [6:0]  crc;
        logic        fb;
        body = {2'b01, idx, arg};
        crc  = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = crc[6] ^ body[i];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {body, crc, 1'b1};
    endfunction

    // Returns #1 after edge N+49 (first cycle after the end bit).
    task automatic run_tx(input logic [5:0] idx, input logic [31:0] arg, input logic resp,
                          input logic glitch, output logic [47:0] frame);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b1;
        i_cmd_index = idx;
        i_cmd_arg = arg;
        i_resp_expected = resp;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_cmd_index = '0;
        i_cmd_arg = '0;
        i_resp_expected = 1'b0;
        check("busy_after_start", {63'd0, o_busy}, 64'd1);
        check("oe_after_start", {63'd0, o_cmd_oe}, 64'd1);
        check("flags_cleared_on_start", {56'd0, o_timeout, o_crc_err, o_resp_index}, 64'd0);
        for (int k = 47; k >= 0; k--) begin
            frame[k] = o_cmd_out;
            if (glitch && k == 30) begin
                i_start = 1'b1;
                i_cmd_index = 6'h3F;
                i_cmd_arg = 32'hFFFF_FFFF;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
    endtask

    // Card drives frame after `delay` edges; returns #1 after edge S+48.
    task automatic respond(input logic [47:0] f, input int delay);
        repeat (delay) @(posedge clk);
        for (int k = 47; k >= 0; k--) begin
            @(negedge clk);
            i_cmd_in = f[k];
        end
        @(posedge clk);
        #1;
        check("rx_done_not_early", {63'd0, o_done}, 64'd0);
        @(negedge clk);
        i_cmd_in = 1'b1;
        @(posedge clk);
        #1;
        check("rx_done_at_s48", {63'd0, o_done}, 64'd1);
        check("rx_busy_low_at_done", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        logic [47:0] f;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        int          cycles;
        int          n_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {o_cmd_out, o_cmd_oe, o_busy, o_done, o_crc_err, o_timeout, o_resp_index},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
        check("reset_resp_arg", {32'd0, o_resp_arg}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // CMD0, no response
        push("cmd0_frame", 64'h40_0000_0000_95);
        run_tx(6'd0, 32'd0, 1'b0, 1'b0, f);
        check("cmd0_done_busy_oe_n49", {61'd0, o_done, o_busy, o_cmd_oe}, 64'b100);
        pop_check({16'd0, f});
        @(posedge clk);
        #1;
        check("cmd0_after_done", {61'd0, o_done, o_busy, o_cmd_oe}, 64'b000);

        // CMD17 with a start pulse during TX, and a start in the DONE cycle
        push("cmd17_frame_glitch", 64'h51_0000_0000_55);
        run_tx(6'd17, 32'd0, 1'b0, 1'b1, f);
        check("cmd17_done_n49", {63'd0, o_done}, 64'd1);
        pop_check({16'd0, f});
        i_start = 1'b1;
        i_cmd_index = 6'd5;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check("start_in_done_ignored", {62'd0, o_busy, o_cmd_oe}, 64'd0);
        @(posedge clk);
        #1;
        check("start_in_done_still_idle", {63'd0, o_busy}, 64'd0);

        // CMD8, arg 0x1AA
        push("cmd8_frame", 64'h48_0000_01AA_87);
        run_tx(6'd8, 32'h0000_01AA, 1'b0, 1'b0, f);
        pop_check({16'd0, f});

        // Random command against the reference CRC model
        ridx = 6'($urandom);
        rarg = $urandom;
        push("random_frame", {16'd0, model_frame(ridx, rarg)});
        run_tx(ridx, rarg, 1'b0, 1'b0, f);
        pop_check({16'd0, f});

        // CMD17 with a good R1 response
        push("cmd17r_frame", 64'h51_0000_0000_55);
        push("resp_index", 64'h11);
        push("resp_arg", 64'h0000_0900);
        push("resp_crc_err", 64'd0);
        push("resp_timeout", 64'd0);
        run_tx(6'd17, 32'd0, 1'b1, 1'b0, f);
        pop_check({16'd0, f});
        check("turn_oe_low_busy_high", {61'd0, o_done, o_busy, o_cmd_oe}, 64'b010);
        respond(48'h11_0000_0900_67, 10);
        pop_check({58'd0, o_resp_index});
        pop_check({32'd0, o_resp_arg});
        pop_check({63'd0, o_crc_err});
        pop_check({63'd0, o_timeout});

        // Same response with one CRC bit flipped
        push("bad_resp_index", 64'h11);
        push("bad_resp_crc_err", {63'd0, c_BAD_CRC_FLAG});
        run_tx(6'd17, 32'd0, 1'b1, 1'b0, f);
        respond(48'h11_0000_0900_67 ^ 48'h2, 10);
        pop_check({58'd0, o_resp_index});
        pop_check({63'd0, o_crc_err});

        // No card response: timeout
        push("timeout_latency", 64'(51 + RESP_TIMEOUT + 1));
        run_tx(6'd55, 32'h1234_5678, 1'b1, 1'b0, f);
        cycles = 49;
        while (o_done !== 1'b1 && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        pop_check(64'(cycles));
        check("timeout_flag", {63'd0, o_timeout}, 64'd1);
        check("timeout_resp_cleared", {26'd0, o_resp_index, o_resp_arg}, 64'd0);
        check("timeout_crc_err_cleared", {63'd0, o_crc_err}, 64'd0);

        // Reset in the middle of TX
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b1;
        i_cmd_index = 6'd17;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_tx", {61'd0, o_cmd_oe, o_busy, o_cmd_out}, 64'b001);
        check("reset_clears_timeout", {63'd0, o_timeout}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) n_done++;
        end
        check("no_done_after_reset", 64'(n_done), 64'd0);

        // Normal operation after reset
        push("cmd0_after_reset", 64'h40_0000_0000_95);
        run_tx(6'd0, 32'd0, 1'b0, 1'b0, f);
        pop_check({16'd0, f});

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
